rs232rx: RTL

- 8N1 RS-232 receiver; the receive-side counterpart of the team's serial transmitter.
- Synchronises the asynchronous serial line and validates the start bit at mid-bit.
- Samples 8 data bits LSB-first and checks the stop bit.
- Holds each received byte in an output register until the consumer acknowledges it. Sits between the board RX pin and the CPU/IO bus.

---
 rtl/rs232rx_if.sv | 27 ++
 rtl/rs232rx.sv | 138 +++++++++++++
 2 files changed

// File: rtl/rs232rx_if.sv
// Consumer-side bundle of the 8N1 receiver: received byte, handshake and status pulses.
interface rs232rx_if;
  logic [7:0] q;
  logic       valid;
  logic       re;
  logic       framing_error;
  logic       overrun;
  logic       busy;

  modport master (
    output q,
    output valid,
    output framing_error,
    output overrun,
    output busy,
    input  re
  );

  modport slave (
    input  q,
    input  valid,
    input  framing_error,
    input  overrun,
    input  busy,
    output re
  );
endinterface

// File: rtl/rs232rx.sv
// 8N1 RS-232 receiver: two-flop line synchroniser, mid-bit sampling FSM and a
// held output register with valid/re handshake, framing-error and overrun pulses.
module rs232rx #(
  parameter int unsigned frequency   = 0,
  parameter int unsigned bps         = 0,
  parameter int unsigned period      = (bps == 0) ? 4 : (frequency + bps / 2) / bps,
  parameter int unsigned TTYCLK_SIGN = 16
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       serial_in,
  rs232rx_if.master  bus
);

  localparam int unsigned half = period >> 1;
  localparam int unsigned cnt_w = TTYCLK_SIGN + 1;
  localparam logic [TTYCLK_SIGN:0] half_load   = cnt_w'(half - 1);
  localparam logic [TTYCLK_SIGN:0] period_load = cnt_w'(period - 1);
  localparam logic [TTYCLK_SIGN:0] cnt_one     = 1;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StDone,
    StBreak
  } state_e;

  state_e              state_q, state_d;
  logic [1:0]          sync_q;
  logic [TTYCLK_SIGN:0] cnt_q, cnt_d;
  logic [2:0]          bit_q, bit_d;
  logic [7:0]          shift_q, shift_d;
  logic                stop_q, stop_d;
  logic [7:0]          q_q, q_d;
  logic                valid_q, valid_d;
  logic                fe_q, fe_d;
  logic                ovr_q, ovr_d;
  logic                rx_s;
  logic                cnt_zero;

  assign rx_s     = sync_q[1];
  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q - cnt_one;
    bit_d   = bit_q;
    shift_d = shift_q;
    stop_d  = stop_q;
    q_d     = q_q;
    valid_d = valid_q & ~bus.re;
    fe_d    = 1'b0;
    ovr_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = half_load;
        if (!rx_s) state_d = StStart;
      end
      StStart: begin
        if (cnt_zero) begin
          if (rx_s) begin
            state_d = StIdle;
          end else begin
            state_d = StData;
            bit_d   = 3'd0;
            cnt_d   = period_load;
          end
        end
      end
      StData: begin
        if (cnt_zero) begin
          shift_d = {rx_s, shift_q[7:1]};
          cnt_d   = period_load;
          if (bit_q == 3'd7) state_d = StStop;
          else               bit_d   = bit_q + 3'd1;
        end
      end
      StStop: begin
        if (cnt_zero) begin
          stop_d  = rx_s;
          state_d = StDone;
        end
      end
      StDone: begin
        // Delivery one edge after the stop sample; re on this edge avoids overrun.
        if (stop_q) begin
          q_d     = shift_q;
          valid_d = 1'b1;
          ovr_d   = valid_q & ~bus.re;
          state_d = StIdle;
        end else begin
          fe_d    = 1'b1;
          state_d = StBreak;
        end
      end
      StBreak: begin
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      sync_q  <= 2'b11;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'h00;
      stop_q  <= 1'b0;
      q_q     <= 8'h00;
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= {sync_q[0], serial_in};
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      stop_q  <= stop_d;
      q_q     <= q_d;
      valid_q <= valid_d;
      fe_q    <= fe_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.q             = q_q;
  assign bus.valid         = valid_q;
  assign bus.framing_error = fe_q;
  assign bus.overrun       = ovr_q;
  assign bus.busy          = (state_q != StIdle);

endmodule
